apb_master_arb: RTL and testbench

- APB master front-end that shares one APB bus between NUM_REQ local requesters.
- Arbitrates among pending requests round-robin and sequences the granted transfer through APB IDLE -> SETUP -> ACCESS.
- Returns read data or error to the owning requester.
- Bounds slave wait states with a timeout counter so a hung slave cannot lock the bus.

---
 rtl/apb_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/apb_master_arb.sv | 203 ++++++++++++++++++++
 tb/tb_apb_master_arb.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// -----------------------------------------------------------------------------
// apb_arb_pkg
//   Shared types and defaults for the APB master front-end.
//   - apb_mstate_t : APB master sequencing states (IDLE -> SETUP -> ACCESS)
//   - DEF_*        : default parameter values for apb_master_arb
//   - idx_width()  : width of an index into an n-entry vector (at least 1 bit)
// -----------------------------------------------------------------------------
package apb_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } apb_mstate_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker. The search starts at the
//   requester after last_grant and wraps, so last_grant itself has the lowest
//   priority. The owner of the design keeps the last_grant register.
//
//   Ports:
//     req        in   NUM_REQ  pending requests
//     last_grant in   IDX_W    index granted most recently
//     grant      out  NUM_REQ  one-hot winner (all zero when nothing pending)
//     grant_idx  out  IDX_W    binary index of the winner
//     any_grant  out  1        at least one request pending
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        // Walk offsets 1..NUM_REQ from the pointer; offset NUM_REQ lands back
        // on last_grant, which therefore only wins when it is alone.
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(last_grant) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!any_grant && req[cand_idx]) begin
                any_grant       = 1'b1;
                grant_idx       = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// -----------------------------------------------------------------------------
// apb_master_arb
//   Shares one APB bus between NUM_REQ local requesters. A round-robin winner
//   is accepted in S_IDLE, then driven through SETUP and ACCESS. The result
//   (read data or timeout error) is returned to the owner with a one-cycle
//   rsp_valid strobe. A wait-state counter aborts the transfer after TIMEOUT
//   consecutive ACCESS cycles with PREADY low.
//
//   Ports:
//     PCLK, PRESET            clock, asynchronous active-high reset
//     req_valid/write         per-requester request and direction
//     req_addr/req_wdata      packed per-requester address / write data
//     req_ready               one-hot acceptance strobe (combinational, S_IDLE)
//     rsp_valid               one-hot completion strobe, one cycle
//     rsp_rdata/rsp_err       response payload, held until the next response
//     PSEL/PENABLE/PWRITE/
//     PADDR/PWDATA            registered APB master outputs
//     PRDATA/PREADY           APB slave returns
// -----------------------------------------------------------------------------
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // -------------------------------------------------------------------------
    // Unpack the flat request buses
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] req_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] req_wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign req_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    apb_mstate_t          state_reg,      state_next;
    logic [IDX_W-1:0]     last_grant_reg, last_grant_next;
    logic [CNT_W-1:0]     wait_cnt_reg,   wait_cnt_next;
    logic                 psel_reg,       psel_next;
    logic                 penable_reg,    penable_next;
    logic                 pwrite_reg,     pwrite_next;
    logic [ADDR_W-1:0]    paddr_reg,      paddr_next;
    logic [DATA_W-1:0]    pwdata_reg,     pwdata_next;
    logic [NUM_REQ-1:0]   rsp_valid_reg,  rsp_valid_next;
    logic [DATA_W-1:0]    rsp_rdata_reg,  rsp_rdata_next;
    logic                 rsp_err_reg,    rsp_err_next;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any_grant  (arb_any)
    );

    // Acceptance is only offered in S_IDLE; it is masked while reset is held
    // so no requester believes it was accepted by a design that is in reset.
    assign req_ready = (state_reg == S_IDLE && !PRESET) ? arb_grant : '0;

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        wait_cnt_next   = wait_cnt_reg;
        psel_next       = psel_reg;
        penable_next    = penable_reg;
        pwrite_next     = pwrite_reg;
        paddr_next      = paddr_reg;
        pwdata_next     = pwdata_reg;
        rsp_valid_next  = '0;
        rsp_rdata_next  = rsp_rdata_reg;
        rsp_err_next    = rsp_err_reg;

        case (state_reg)
            S_IDLE: begin
                if (arb_any) begin
                    state_next      = S_SETUP;
                    last_grant_next = arb_idx;
                    pwrite_next     = req_write[arb_idx];
                    paddr_next      = req_addr_arr[arb_idx];
                    pwdata_next     = req_wdata_arr[arb_idx];
                    psel_next       = 1'b1;
                    penable_next    = 1'b0;
                end
            end

            S_SETUP: begin
                state_next   = S_ACCESS;
                penable_next = 1'b1;
            end

            S_ACCESS: begin
                if (PREADY) begin
                    state_next                     = S_IDLE;
                    psel_next                      = 1'b0;
                    penable_next                   = 1'b0;
                    wait_cnt_next                  = '0;
                    rsp_valid_next[last_grant_reg] = 1'b1;
                    rsp_rdata_next                 = pwrite_reg ? '0 : PRDATA;
                    rsp_err_next                   = 1'b0;
                end else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th stalled ACCESS cycle: give up.
                    state_next                     = S_IDLE;
                    psel_next                      = 1'b0;
                    penable_next                   = 1'b0;
                    wait_cnt_next                  = '0;
                    rsp_valid_next[last_grant_reg] = 1'b1;
                    rsp_rdata_next                 = '0;
                    rsp_err_next                   = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next   = S_IDLE;
                psel_next    = 1'b0;
                penable_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg      <= S_IDLE;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            wait_cnt_reg   <= '0;
            psel_reg       <= 1'b0;
            penable_reg    <= 1'b0;
            pwrite_reg     <= 1'b0;
            paddr_reg      <= '0;
            pwdata_reg     <= '0;
            rsp_valid_reg  <= '0;
            rsp_rdata_reg  <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            wait_cnt_reg   <= wait_cnt_next;
            psel_reg       <= psel_next;
            penable_reg    <= penable_next;
            pwrite_reg     <= pwrite_next;
            paddr_reg      <= paddr_next;
            pwdata_reg     <= pwdata_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_rdata_reg  <= rsp_rdata_next;
            rsp_err_reg    <= rsp_err_next;
        end
    end

    assign PSEL      = psel_reg;
    assign PENABLE   = penable_reg;
    assign PWRITE    = pwrite_reg;
    assign PADDR     = paddr_reg;
    assign PWDATA    = pwdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb_master_arb.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arb
//   Self-checking bench for apb_master_arb. A transaction-level model tracks
//   the bus owner, the cycle its transfer was accepted, its wait states and
//   the pending response; a negedge process compares every DUT output to it
//   each cycle. Directed scenarios add literal expectations on top, followed
//   by a randomized phase with random requests, withdrawals, stalls and a
//   mid-run reset.
// -----------------------------------------------------------------------------
module tb_apb_master_arb;

    localparam int N       = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
    localparam logic [ADDR_W-1:0] WD_ADDR = 32'h0000_1110;

    logic                    PCLK = 1'b0;
    logic                    PRESET = 1'b0;
    logic [N-1:0]            req_valid = '0;
    logic [N-1:0]            req_write = '0;
    logic [N*ADDR_W-1:0]     req_addr = '0;
    logic [N*DATA_W-1:0]     req_wdata = '0;
    logic [N-1:0]            req_ready;
    logic [N-1:0]            rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    rsp_err;
    logic                    PSEL, PENABLE, PWRITE;
    logic [ADDR_W-1:0]       PADDR;
    logic [DATA_W-1:0]       PWDATA;
    logic [DATA_W-1:0]       PRDATA = '0;
    logic                    PREADY = 1'b0;

    apb_master_arb #(
        .NUM_REQ (N),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wd_hits  = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // -------------------------------------------------------------------------
    // Transaction-level reference model + per-cycle compare
    // -------------------------------------------------------------------------
    bit                m_busy = 0;
    int                m_start = 0;
    int                m_owner = 0;
    int                m_last = N - 1;
    int                m_waits = 0;
    logic              m_write = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    bit                m_rsp_pend = 0;
    int                m_rsp_owner = 0;
    logic [DATA_W-1:0] m_rsp_rdata = '0;
    logic              m_rsp_err = 1'b0;

    always @(negedge PCLK) begin
        int           g;
        int           age;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rsp;
        cyc++;
        if (PRESET) begin
            m_busy = 0; m_last = N - 1; m_waits = 0;
            m_write = 1'b0; m_addr = '0; m_wdata = '0;
            m_rsp_pend = 0; m_rsp_rdata = '0; m_rsp_err = 1'b0;
            cmp("rst_psel", PSEL, 0);
            cmp("rst_penable", PENABLE, 0);
            cmp("rst_paddr", PADDR, 0);
            cmp("rst_rsp_valid", rsp_valid, 0);
            cmp("rst_req_ready", req_ready, 0);
            cmp("rst_rsp_rdata", rsp_rdata, 0);
            cmp("rst_rsp_err", rsp_err, 0);
        end else begin
            g = -1;
            exp_ready = '0;
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (g < 0 && req_valid[c]) g = c;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            age = cyc - m_start;
            exp_rsp = '0;
            if (m_rsp_pend) exp_rsp[m_rsp_owner] = 1'b1;

            cmp("req_ready", req_ready, exp_ready);
            cmp("psel", PSEL, m_busy);
            cmp("penable", PENABLE, m_busy && age >= 2);
            cmp("pwrite", PWRITE, m_write);
            cmp("paddr", PADDR, m_addr);
            cmp("pwdata", PWDATA, m_wdata);
            cmp("rsp_valid", rsp_valid, exp_rsp);
            cmp("rsp_rdata", rsp_rdata, m_rsp_rdata);
            cmp("rsp_err", rsp_err, m_rsp_err);
            if (PSEL && !PENABLE && PADDR == WD_ADDR) wd_hits++;

            // What the coming rising edge does.
            m_rsp_pend = 0;
            if (!m_busy) begin
                if (g >= 0) begin
                    m_busy  = 1;
                    m_start = cyc;
                    m_owner = g;
                    m_last  = g;
                    m_waits = 0;
                    m_write = req_write[g];
                    m_addr  = req_addr[g*ADDR_W +: ADDR_W];
                    m_wdata = req_wdata[g*DATA_W +: DATA_W];
                end
            end else if (age >= 2) begin
                if (PREADY) begin
                    m_busy      = 0;
                    m_rsp_pend  = 1;
                    m_rsp_owner = m_owner;
                    m_rsp_rdata = m_write ? '0 : PRDATA;
                    m_rsp_err   = 1'b0;
                end else begin
                    m_waits++;
                    if (m_waits == TIMEOUT) begin
                        m_busy      = 0;
                        m_rsp_pend  = 1;
                        m_rsp_owner = m_owner;
                        m_rsp_rdata = '0;
                        m_rsp_err   = 1'b1;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    bit           auto_drop = 1;
    logic [N-1:0] acc = '0;

    // Advance one cycle; requesters that were accepted drop their request.
    task automatic tick();
        @(negedge PCLK);
        acc = req_ready;
        @(posedge PCLK);
        #1;
        if (auto_drop) req_valid = req_valid & ~acc;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        bit done;
        int hang;

        // ---------------- reset ----------------
        #2 PRESET = 1'b1;
        tick(); tick();
        cmp("lit_rst_psel", PSEL, 0);
        cmp("lit_rst_rsp_valid", rsp_valid, 0);
        PRESET = 1'b0;
        tick();

        // ---------------- write, zero wait ----------------
        set_req(0, 1'b1, 32'h10, 32'hA5);
        PREADY = 1'b1;
        #1 cmp("wr_ready_T", req_ready, 4'b0001);
        tick();
        cmp("wr_psel_T1", PSEL, 1);
        cmp("wr_penable_T1", PENABLE, 0);
        tick();
        cmp("wr_penable_T2", PENABLE, 1);
        cmp("wr_paddr_T2", PADDR, 32'h10);
        cmp("wr_pwdata_T2", PWDATA, 32'hA5);
        cmp("wr_pwrite_T2", PWRITE, 1);
        tick();
        cmp("wr_rsp_valid_T3", rsp_valid, 4'b0001);
        cmp("wr_rsp_err_T3", rsp_err, 0);
        $display("txn write req0 addr=0x10 done");

        // ---------------- read, two wait states ----------------
        tick();
        set_req(2, 1'b0, 32'h40, 32'h0);
        PREADY = 1'b0;
        #1 cmp("rd_ready_T", req_ready, 4'b0100);
        tick();
        cmp("rd_paddr_T1", PADDR, 32'h40);
        tick();
        cmp("rd_paddr_T2", PADDR, 32'h40);
        tick();
        cmp("rd_paddr_T3", PADDR, 32'h40);
        tick();
        PREADY = 1'b1;
        PRDATA = 32'hDEAD_BEEF;
        cmp("rd_paddr_T4", PADDR, 32'h40);
        tick();
        cmp("rd_rsp_valid_T5", rsp_valid, 4'b0100);
        cmp("rd_rsp_rdata_T5", rsp_rdata, 32'hDEAD_BEEF);
        $display("txn read req2 addr=0x40 rdata=0x%0h", rsp_rdata);

        // ---------------- fairness ----------------
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        auto_drop = 0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, ADDR_W'(32'h100 + i * 4), DATA_W'(i));
        for (int k = 0; k < 18; k++) begin
            logic [N-1:0] exp_g;
            exp_g = '0;
            if (k % 3 == 0) exp_g[(k / 3) % N] = 1'b1;
            #1 cmp("fair_grant", req_ready, exp_g);
            if (exp_g != 0) $display("txn fair grant=0b%b cycle=%0d", req_ready, k);
            tick();
        end
        req_valid = '0;
        auto_drop = 1;
        tick(); tick();

        // ---------------- timeout ----------------
        set_req(1, 1'b0, 32'h80, 32'h0);
        PREADY = 1'b0;
        #1 cmp("to_ready_T", req_ready, 4'b0010);
        cnt = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (!PSEL) done = 1;
            else if (PENABLE) cnt++;
        end
        cmp("to_access_cycles", cnt, TIMEOUT);
        cmp("to_rsp_valid", rsp_valid, 4'b0010);
        cmp("to_rsp_err", rsp_err, 1);
        cmp("to_rsp_rdata", rsp_rdata, 0);
        $display("txn timeout req1 access_cycles=%0d err=%0d", cnt, rsp_err);
        PREADY = 1'b1;
        set_req(0, 1'b1, 32'h20, 32'h55);
        #1 cmp("to_next_ready", req_ready, 4'b0001);
        tick(); tick(); tick();
        cmp("to_next_rsp_valid", rsp_valid, 4'b0001);
        cmp("to_next_rsp_err", rsp_err, 0);
        $display("txn write req0 after timeout err=%0d", rsp_err);

        // ---------------- reset mid-ACCESS ----------------
        set_req(3, 1'b0, 32'h30, 32'h0);
        PREADY = 1'b0;
        #1 cmp("rm_ready_T", req_ready, 4'b1000);
        tick(); tick();
        cmp("rm_penable_T2", PENABLE, 1);
        PRESET = 1'b1;
        set_req(0, 1'b1, 32'h60, 32'h66);
        set_req(3, 1'b0, 32'h30, 32'h0);
        #1;
        cmp("rm_psel_now", PSEL, 0);
        cmp("rm_penable_now", PENABLE, 0);
        cmp("rm_rsp_valid_now", rsp_valid, 0);
        tick();
        PRESET = 1'b0;
        PREADY = 1'b1;
        #1 cmp("rm_first_grant", req_ready, 4'b0001);
        cmp("rm_no_rsp", rsp_valid, 0);
        tick(); tick(); tick();
        cmp("rm_rsp0", rsp_valid, 4'b0001);
        cmp("rm_second_grant", req_ready, 4'b1000);
        tick(); tick(); tick();
        $display("txn reset-kill req3, then req0 and req3 served");

        // ---------------- withdrawal ----------------
        set_req(0, 1'b1, 32'h50, 32'h77);
        PREADY = 1'b0;
        #1 cmp("wd_ready_T", req_ready, 4'b0001);
        tick();
        set_req(1, 1'b0, WD_ADDR, 32'h0);
        #1 cmp("wd_ready_busy", req_ready, 4'b0000);
        tick();
        req_valid[1] = 1'b0;
        tick(); tick();
        PREADY = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        cmp("wd_never_granted", wd_hits, 0);
        $display("txn withdrawal req1 hits=%0d", wd_hits);

        // ---------------- randomized traffic ----------------
        hang = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, 1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom));
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            if (hang > 0) begin
                PREADY = 1'b0;
                hang--;
            end else if ($urandom_range(0, 59) == 0) begin
                hang = 20;
                PREADY = 1'b0;
            end else begin
                PREADY = ($urandom_range(0, 3) != 0);
            end
            PRDATA = DATA_W'($urandom);
            PRESET = (c >= 700 && c < 702);
            tick();
            if (rsp_valid != 0)
                $display("txn rnd rsp=0b%b err=%0d rdata=0x%0h", rsp_valid, rsp_err, rsp_rdata);
        end
        PRESET = 1'b0;
        req_valid = '0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
